// File: rtl/noc_rr_arbiter_pkg.sv
// Shared definitions for the packet-locking round-robin arbiter.
//   arb_state_e  : IDLE / LOCKED arbiter state
//   onehot2idx   : one-hot (up to 16 bits) to binary index
//   STARV_CNT_W  : width of a counter that must hold the starvation threshold
package noc_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic logic [3:0] onehot2idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx |= 4'(i);
    end
    return idx;
  endfunction

  function automatic int STARV_CNT_W(input int thresh);
    return $clog2(thresh + 1);
  endfunction

endpackage

// File: rtl/noc_rr_arbiter_if.sv
// Request/grant bundle between the input channels and one output-port arbiter.
//   req, last, out_ready             : driven by channels / downstream (master)
//   grant, grant_valid, grant_idx,
//   starved                          : driven by the arbiter (slave)
interface noc_rr_arbiter_if #(
  parameter int NUM_AGENTS = 4
) ();
  localparam int IDX_W = $clog2(NUM_AGENTS);

  logic [NUM_AGENTS-1:0] req;
  logic [NUM_AGENTS-1:0] last;
  logic                  out_ready;
  logic [NUM_AGENTS-1:0] grant;
  logic                  grant_valid;
  logic [IDX_W-1:0]      grant_idx;
  logic [NUM_AGENTS-1:0] starved;

  modport master (
    output req, last, out_ready,
    input  grant, grant_valid, grant_idx, starved
  );

  modport slave (
    input  req, last, out_ready,
    output grant, grant_valid, grant_idx, starved
  );
endinterface

// File: rtl/noc_rr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   vec     : candidate vector
//   ptr     : highest-priority index (0..N-1)
//   pick_oh : one-hot first set bit of vec searching ptr, ptr+1, ... modulo N
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick_oh
);
  logic          found;
  logic [PW:0]   idx;

  always_comb begin
    pick_oh = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      // ptr + k < 2N, so a single conditional subtract gives the modulo
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      if (!found && vec[idx[PW-1:0]]) begin
        pick_oh[idx[PW-1:0]] = 1'b1;
        found                = 1'b1;
      end
    end
  end
endmodule

// File: rtl/noc_rr_arbiter.sv
// Packet-locking round-robin arbiter for a NoC router output port.
// Grants one channel, holds the grant until that channel's tail flit
// transfers, then rotates priority to the channel after the winner.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : noc_rr_arbiter_if.slave (req/last/out_ready in,
//                grant/grant_valid/grant_idx/starved out)
// Build option: NOC_ARB_STARV_EN compiles in per-channel starvation
// counters and the starved-first pick; without it starved is 0 and the
// pick is plain round-robin.
//
// state  | meaning
// IDLE   | no grant; pick a winner if any req is set
// LOCKED | grant held until granted channel transfers with last
module noc_rr_arbiter
  import noc_arb_pkg::*;
#(
  parameter int NUM_AGENTS   = 4,
  parameter int STARV_THRESH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  noc_rr_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_AGENTS);

  if (NUM_AGENTS < 2 || NUM_AGENTS > 16 || STARV_THRESH < 1 || STARV_THRESH > 255) begin : g_bad_param
    $error("noc_rr_arbiter: parameter out of range");
  end

  arb_state_e            state_q;
  logic [NUM_AGENTS-1:0] grant_q;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      ptr_q;
  logic [NUM_AGENTS-1:0] starved;
  logic [NUM_AGENTS-1:0] pick_oh;
  logic [NUM_AGENTS-1:0] pick_r;
  logic                  release_w;

  rr_pick #(.N(NUM_AGENTS), .PW(IDX_W)) u_pick_req (
    .vec     (bus.req),
    .ptr     (ptr_q),
    .pick_oh (pick_r)
  );

`ifdef NOC_ARB_STARV_EN
  localparam int CNT_W = STARV_CNT_W(STARV_THRESH);
  localparam logic [CNT_W-1:0] THRESH = CNT_W'(STARV_THRESH);

  logic [CNT_W-1:0]      cnt_q [NUM_AGENTS];
  logic [CNT_W-1:0]      cnt_d [NUM_AGENTS];
  logic [NUM_AGENTS-1:0] pick_s;
  logic [NUM_AGENTS-1:0] req_starved;

  always_comb begin
    for (int i = 0; i < NUM_AGENTS; i++) begin
      cnt_d[i]   = cnt_q[i];
      starved[i] = (cnt_q[i] == THRESH);
      if (!bus.req[i] || grant_q[i]) cnt_d[i] = '0;
      else if (cnt_q[i] != THRESH)   cnt_d[i] = cnt_q[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_AGENTS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_AGENTS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign req_starved = bus.req & starved;

  rr_pick #(.N(NUM_AGENTS), .PW(IDX_W)) u_pick_starved (
    .vec     (req_starved),
    .ptr     (ptr_q),
    .pick_oh (pick_s)
  );

  assign pick_oh = (|req_starved) ? pick_s : pick_r;
`else
  assign starved = '0;
  assign pick_oh = pick_r;
`endif

  // A stalled tail flit (out_ready low) keeps the lock.
  assign release_w = (|(grant_q & bus.req & bus.last)) && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus.req) begin
            grant_q <= pick_oh;
            idx_q   <= IDX_W'(onehot2idx(16'(pick_oh)));
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          // New requests seen in the release cycle wait for the IDLE bubble.
          if (release_w) begin
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= (idx_q == IDX_W'(NUM_AGENTS-1)) ? '0 : idx_q + IDX_W'(1);
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = |grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.starved     = starved;
endmodule

// File: tb/tb_noc_rr_arbiter.sv
module tb_noc_rr_arbiter;
  import noc_arb_pkg::*;

  localparam int N  = 4;
  localparam int TH = 4;
`ifdef NOC_ARB_STARV_EN
  localparam bit STARV_EN = 1'b1;
`else
  localparam bit STARV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   proto_viol = 0;

  always #5 clk = ~clk;

  noc_rr_arbiter_if #(.NUM_AGENTS(N)) bus ();
  noc_rr_arbiter_if #(.NUM_AGENTS(3)) bus3 ();

  noc_rr_arbiter #(.NUM_AGENTS(N), .STARV_THRESH(TH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  noc_rr_arbiter #(.NUM_AGENTS(3), .STARV_THRESH(TH)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );

  // Protocol monitor: a granted channel must keep req high until its tail.
  always @(posedge clk) begin
    if (rst_n && |(bus.grant & ~bus.req)) begin
      proto_viol++;
      $display("note: protocol violation, granted channel dropped req (grant=%b req=%b)", bus.grant, bus.req);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  bit m_locked;
  int m_owner;
  int m_ptr;
  int m_wait [N];

  function automatic int first_from(input logic [N-1:0] cand, input int start);
    for (int k = 0; k < N; k++) begin
      if (cand[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_starved();
    logic [N-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s[i] = STARV_EN && (m_wait[i] >= TH);
    return s;
  endfunction

  function automatic logic [N-1:0] m_grant();
    return m_locked ? (N'(1) << m_owner) : '0;
  endfunction

  function automatic int m_idx();
    return m_locked ? m_owner : 0;
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_ptr    = 0;
    for (int i = 0; i < N; i++) m_wait[i] = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] r;
    logic [N-1:0] st;
    int w;
    bit nl;
    int no, np;
    r  = bus.req;
    st = m_starved();
    nl = m_locked; no = m_owner; np = m_ptr;
    if (!m_locked) begin
      if (r != '0) begin
        w = first_from(r & st, m_ptr);
        if (w < 0) w = first_from(r, m_ptr);
        nl = 1'b1;
        no = w;
      end
    end else if (r[m_owner] && bus.last[m_owner] && bus.out_ready) begin
      nl = 1'b0;
      np = (m_owner + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (!r[i] || (m_locked && m_owner == i)) m_wait[i] = 0;
      else if (m_wait[i] < TH) m_wait[i]++;
    end
    m_locked = nl; m_owner = no; m_ptr = np;
  endtask

  // Advance one clock: model consumes current inputs, DUT samples them at posedge.
  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l, input logic rdy);
    bus.req = r; bus.last = l; bus.out_ready = rdy;
  endtask

  task automatic do_reset();
    drive('0, '0, 1'b1);
    bus3.req = '0; bus3.last = '0; bus3.out_ready = 1'b1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive('0, '0, 1'b1);
    bus3.req = '0; bus3.last = '0; bus3.out_ready = 1'b1;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    drive('1, '1, 1'b1);
    bus3.req = '1;
    repeat (2) @(negedge clk);
    checks++; if (bus.grant !== 4'b0000) begin failures++; $display("FAIL reset_grant: got %b expected 0000", bus.grant); end
    checks++; if (bus.grant_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bus.grant_valid); end
    checks++; if (bus.grant_idx !== 2'd0) begin failures++; $display("FAIL reset_idx: got %0d expected 0", bus.grant_idx); end
    checks++; if (bus.starved !== 4'b0000) begin failures++; $display("FAIL reset_starved: got %b expected 0000", bus.starved); end
    checks++; if (bus3.grant !== 3'b000) begin failures++; $display("FAIL reset_grant3: got %b expected 000", bus3.grant); end
    do_reset();
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    int         exp_i [9] = '{0, 0, 1, 0, 2, 0, 3, 0, 0};
    do_reset();
    drive(4'b1111, 4'b1111, 1'b1);
    for (int s = 0; s < 9; s++) begin
      tick();
      checks++; if (bus.grant !== exp_g[s]) begin failures++; $display("FAIL rotation_grant step %0d: got %b expected %b", s, bus.grant, exp_g[s]); end
      checks++; if (bus.grant_idx !== 2'(exp_i[s])) begin failures++; $display("FAIL rotation_idx step %0d: got %0d expected %0d", s, bus.grant_idx, exp_i[s]); end
      checks++; if (bus.grant_valid !== (exp_g[s] != 0)) begin failures++; $display("FAIL rotation_valid step %0d: got %b", s, bus.grant_valid); end
    end
  endtask

  task automatic test_stall();
    logic       rdy_t  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] last_t [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
    do_reset();
    drive(4'b0100, 4'b0000, 1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus.grant !== 4'b0100) begin failures++; $display("FAIL stall_hold cycle %0d: got %b expected 0100", k, bus.grant); end
      drive(4'b0100, last_t[k], rdy_t[k]);
      tick();
    end
    checks++; if (bus.grant !== 4'b0000) begin failures++; $display("FAIL stall_release: got %b expected 0000", bus.grant); end
    drive(4'b1111, 4'b0000, 1'b1);
    tick();
    checks++; if (bus.grant !== 4'b1000) begin failures++; $display("FAIL stall_ptr3: got %b expected 1000", bus.grant); end
  endtask

  task automatic test_wrap3();
    do_reset();
    bus3.req = 3'b100; bus3.last = 3'b100; bus3.out_ready = 1'b1;
    tick();
    checks++; if (bus3.grant !== 3'b100 || bus3.grant_idx !== 2'd2) begin failures++; $display("FAIL wrap3_grant2: got %b/%0d expected 100/2", bus3.grant, bus3.grant_idx); end
    bus3.req = 3'b111; bus3.last = 3'b111;
    tick();
    checks++; if (bus3.grant !== 3'b000) begin failures++; $display("FAIL wrap3_release: got %b expected 000", bus3.grant); end
    bus3.req = 3'b011; bus3.last = 3'b000;
    tick();
    checks++; if (bus3.grant !== 3'b001 || bus3.grant_idx !== 2'd0) begin failures++; $display("FAIL wrap3_ptr0: got %b/%0d expected 001/0", bus3.grant, bus3.grant_idx); end
    bus3.req = '0;
  endtask

  task automatic test_starvation();
    logic [3:0] exp_st;
    logic [3:0] exp_g;
    // Both 1 and 3 starved, ptr=3 after agent 2 releases.
    do_reset();
    drive(4'b0100, 4'b0000, 1'b1);
    tick();
    for (int k = 0; k < 6; k++) begin drive(4'b1110, 4'b0000, 1'b1); tick(); end
    exp_st = STARV_EN ? 4'b1010 : 4'b0000;
    checks++; if (bus.starved !== exp_st || bus.starved !== m_starved()) begin failures++; $display("FAIL starv_both_flags: got %b expected %b", bus.starved, exp_st); end
    drive(4'b1110, 4'b0100, 1'b1);
    tick();
    drive(4'b1010, 4'b0000, 1'b1);
    tick();
    checks++; if (bus.grant !== 4'b1000 || bus.grant !== m_grant()) begin failures++; $display("FAIL starv_both_pick: got %b expected 1000", bus.grant); end
    drive(4'b1010, 4'b1010, 1'b1);
    tick();
    tick();
    checks++; if (bus.grant !== 4'b0010) begin failures++; $display("FAIL starv_both_next: got %b expected 0010", bus.grant); end
    // Only agent 1 starved; agent 3 joins late.
    do_reset();
    drive(4'b0100, 4'b0000, 1'b1);
    tick();
    for (int k = 0; k < 6; k++) begin drive((k >= 4) ? 4'b1110 : 4'b0110, 4'b0000, 1'b1); tick(); end
    drive(4'b1110, 4'b0100, 1'b1);
    tick();
    drive(4'b1010, 4'b0000, 1'b1);
    exp_st = STARV_EN ? 4'b0010 : 4'b0000;
    checks++; if (bus.starved !== exp_st || bus.starved !== m_starved()) begin failures++; $display("FAIL starv_one_flags: got %b expected %b", bus.starved, exp_st); end
    tick();
    exp_g = STARV_EN ? 4'b0010 : 4'b1000;
    checks++; if (bus.grant !== exp_g || bus.grant !== m_grant()) begin failures++; $display("FAIL starv_one_pick: got %b expected %b", bus.grant, exp_g); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    drive(4'b0010, 4'b0000, 1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin drive(4'b1010, 4'b0000, 1'b1); tick(); end
    checks++; if (bus.grant !== 4'b0010 || bus.starved !== m_starved()) begin failures++; $display("FAIL rstmid_pre: got grant %b starved %b expected 0010 %b", bus.grant, bus.starved, m_starved()); end
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (bus.grant !== 4'b0000) begin failures++; $display("FAIL rstmid_grant: got %b expected 0000", bus.grant); end
    checks++; if (bus.grant_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid: got %b expected 0", bus.grant_valid); end
    checks++; if (bus.starved !== 4'b0000) begin failures++; $display("FAIL rstmid_starved: got %b expected 0000", bus.starved); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1111, 4'b1111, 1'b1);
    tick();
    checks++; if (bus.grant !== 4'b0001) begin failures++; $display("FAIL rstmid_first: got %b expected 0001", bus.grant); end
  endtask

  task automatic test_drop_req();
    int viol0;
    do_reset();
    drive(4'b0001, 4'b0000, 1'b1);
    tick();
    viol0 = proto_viol;
    for (int k = 0; k < 4; k++) begin
      drive(4'b1110, 4'b1110, 1'b1);
      tick();
      checks++; if (bus.grant !== 4'b0001) begin failures++; $display("FAIL drop_hold cycle %0d: got %b expected 0001", k, bus.grant); end
    end
    checks++; if (proto_viol <= viol0) begin failures++; $display("FAIL drop_monitor: got %0d violations expected >%0d", proto_viol, viol0); end
    drive(4'b0001, 4'b0001, 1'b1);
    tick();
    checks++; if (bus.grant !== 4'b0000) begin failures++; $display("FAIL drop_recover: got %b expected 0000", bus.grant); end
  endtask

  task automatic test_random();
    logic [N-1:0] r, l;
    logic rdy;
    int errs;
    errs = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      checks++; if (bus.grant !== m_grant()) begin failures++; errs++; if (errs < 10) $display("FAIL rand_grant cyc %0d: got %b expected %b", c, bus.grant, m_grant()); end
      checks++; if (bus.grant_idx !== 2'(m_idx())) begin failures++; errs++; if (errs < 10) $display("FAIL rand_idx cyc %0d: got %0d expected %0d", c, bus.grant_idx, m_idx()); end
      checks++; if (bus.grant_valid !== m_locked) begin failures++; errs++; if (errs < 10) $display("FAIL rand_valid cyc %0d: got %b expected %b", c, bus.grant_valid, m_locked); end
      checks++; if (bus.starved !== m_starved()) begin failures++; errs++; if (errs < 10) $display("FAIL rand_starved cyc %0d: got %b expected %b", c, bus.starved, m_starved()); end
      for (int i = 0; i < N; i++) begin
        r[i] = ($urandom_range(0, 3) != 0);
        l[i] = ($urandom_range(0, 3) == 0);
      end
      if (m_locked) r[m_owner] = 1'b1;
      rdy = ($urandom_range(0, 3) != 0);
      drive(r, l, rdy);
      tick();
    end
  endtask

  initial begin
    drive('0, '0, 1'b1);
    bus3.req = '0; bus3.last = '0; bus3.out_ready = 1'b1;
    model_reset();
    test_reset();
    test_rotation();
    test_stall();
    test_wrap3();
    test_starvation();
    test_reset_mid_packet();
    test_drop_req();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
